// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared opcodes, funct3 size codes, FSM states and decode helpers
package load_store_unit_pkg;

  localparam logic [6:0] OPCODE_L_TYPE = 7'b0000011;
  localparam logic [6:0] OPCODE_S_TYPE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } lsu_state_e;

  function automatic logic funct3_legal(input logic is_load, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = is_load;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    return ((f3[1:0] == 2'b01) && addr_lo[0]) || ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// rtl/load_store_unit_load_align.sv - combinational load lane select with sign/zero extension
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] mem_rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = mem_rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel    = addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    load_data_o = mem_rdata_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data_o = {24'd0, byte_sel};
      F3_HU:   load_data_o = {16'd0, half_sel};
      default: load_data_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store unit; LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] load_data_q, load_data_d;

  logic        is_load, is_store, misalign_trap;
  logic [31:0] aligned_data;

  assign is_load  = (opcode == OPCODE_L_TYPE);
  assign is_store = (opcode == OPCODE_S_TYPE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_trap = misaligned(funct3, addr[1:0]);
`else
  assign misalign_trap = 1'b0;
`endif

  lsu_load_align u_load_align (
    .mem_rdata_i (mem_rdata),
    .addr_lo_i   (addr_lo_q),
    .funct3_i    (funct3_q),
    .load_data_o (aligned_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    load_data_d = load_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (is_load || is_store)) begin
          if (!funct3_legal(is_load, funct3) || misalign_trap) begin
            state_d = ST_ERR;
          end else begin
            // Bus request fields are latched here and held for the whole REQ phase.
            state_d    = ST_REQ;
            cnt_d      = 16'd0;
            mem_we_d   = is_store;
            mem_addr_d = {addr[31:2], 2'b00};
            mem_be_d   = byte_enables(funct3, addr[1:0]);
            funct3_d   = funct3;
            addr_lo_d  = addr[1:0];
            case (funct3[1:0])
              2'b00:   mem_wdata_d = {4{wdata[7:0]}};
              2'b01:   mem_wdata_d = {2{wdata[15:0]}};
              default: mem_wdata_d = wdata;
            endcase
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d = ST_DONE;
          if (!mem_we_q) load_data_d = aligned_data;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      funct3_q    <= 3'd0;
      addr_lo_q   <= 2'd0;
      load_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      load_data_q <= load_data_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERR);
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a behavioural model
module tb_load_store_unit;

  localparam int TO = 4;
  localparam logic [6:0] OPC_L = 7'b0000011;
  localparam logic [6:0] OPC_S = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_load = 32'd0;

  load_store_unit #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd;
    case (f3)
      3'd0: begin v = (rd >> (8 * a[1:0])) & 32'hFF;   if (v[7])  v = v | 32'hFFFFFF00; end
      3'd1: begin v = (rd >> (16 * a[1])) & 32'hFFFF;  if (v[15]) v = v | 32'hFFFF0000; end
      3'd4: v = (rd >> (8 * a[1:0])) & 32'hFF;
      3'd5: v = (rd >> (16 * a[1])) & 32'hFFFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int nbytes, off;
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off    = (nbytes == 1) ? int'(a[1:0]) : (nbytes == 2) ? 2 * int'(a[1]) : 0;
    return 4'(((1 << nbytes) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3[1:0] == 2'd0) return {24'd0, wd[7:0]} * 32'h01010101;
    if (f3[1:0] == 2'd1) return {16'd0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic bit model_trap(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (f3[1:0] == 2'd1 && a % 2 != 0) || (f3[1:0] == 2'd2 && a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int lat, input bit poke);
    bit is_ld, is_st, legal;
    logic [31:0] ea;
    logic [3:0]  eb;
    is_ld = (op == OPC_L);
    is_st = (op == OPC_S);
    legal = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    ea = a & ~32'd3;
    eb = model_be(f3, a);
    @(negedge clk);
    opcode = op; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (!(is_ld || is_st)) begin
      total++;
      if (busy !== 1'b0 || mem_req !== 1'b0)
        $display("FAIL ignored_opcode busy=%b mem_req=%b want 0 0", busy, mem_req);
      if (busy !== 1'b0 || mem_req !== 1'b0) bad++;
      return;
    end
    if (!legal || model_trap(f3, a)) begin
      total++;
      if ({err, done, mem_req, busy} !== 4'b1001) begin
        bad++; $display("FAIL err_entry {err,done,req,busy}=%b want 1001 f3=%0d a=%h", {err, done, mem_req, busy}, f3, a);
      end
      start = poke;
      @(negedge clk);
      start = 1'b0;
      total++;
      if ({busy, err, done} !== 3'b000 || load_data !== exp_load) begin
        bad++; $display("FAIL err_exit busy/err/done=%b load=%h want 000 %h", {busy, err, done}, load_data, exp_load);
      end
      return;
    end
    total++;
    if (mem_req !== 1'b1 || mem_addr !== ea) begin
      bad++; $display("FAIL req_addr req=%b addr=%h want 1 %h", mem_req, mem_addr, ea);
    end
    total++;
    if (mem_be !== eb) begin bad++; $display("FAIL req_be be=%b want %b", mem_be, eb); end
    total++;
    if (mem_we !== is_st) begin bad++; $display("FAIL req_we we=%b want %b", mem_we, is_st); end
    if (is_st) begin
      total++;
      if (mem_wdata !== model_wdata(f3, wd)) begin
        bad++; $display("FAIL req_wdata wdata=%h want %h", mem_wdata, model_wdata(f3, wd));
      end
    end
    for (int k = 1; k <= TO; k++) begin
      mem_ack = (k == lat); mem_rdata = rd; start = poke;
      @(negedge clk);
      mem_ack = 1'b0; start = 1'b0;
      if (k == lat) begin
        if (is_ld) exp_load = model_load(f3, a, rd);
        total++;
        if ({done, err, mem_req, busy} !== 4'b1001) begin
          bad++; $display("FAIL done_pulse {done,err,req,busy}=%b want 1001 lat=%0d", {done, err, mem_req, busy}, lat);
        end
        total++;
        if (load_data !== exp_load) begin
          bad++; $display("FAIL load_data got=%h want=%h f3=%0d a=%h", load_data, exp_load, f3, a);
        end
        break;
      end else if (k == TO) begin
        total++;
        if ({done, err, mem_req, busy} !== 4'b0101 || load_data !== exp_load) begin
          bad++; $display("FAIL timeout {done,err,req,busy}=%b load=%h want 0101 %h", {done, err, mem_req, busy}, load_data, exp_load);
        end
      end else begin
        total++;
        if (mem_req !== 1'b1 || mem_be !== eb || mem_addr !== ea || done !== 1'b0) begin
          bad++; $display("FAIL req_hold req=%b be=%b addr=%h done=%b k=%0d", mem_req, mem_be, mem_addr, done, k);
        end
      end
    end
    start = poke;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, done, err, mem_req} !== 4'b0000) begin
      bad++; $display("FAIL back_idle {busy,done,err,req}=%b want 0000", {busy, done, err, mem_req});
    end
  endtask

  task automatic test_reset();
    total++;
    if ({busy, done, err, mem_req, mem_we} !== 5'b0 || mem_be !== 4'd0 ||
        mem_addr !== 32'd0 || mem_wdata !== 32'd0 || load_data !== 32'd0) begin
      bad++; $display("FAIL reset_state ctl=%b be=%b addr=%h wdata=%h load=%h want all 0",
                      {busy, done, err, mem_req, mem_we}, mem_be, mem_addr, mem_wdata, load_data);
    end
  endtask

  task automatic test_directed();
    run_txn(OPC_L, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 3, 1'b0);
    total++;
    if (load_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_const got=%h want=deadbeef", load_data); end
    run_txn(OPC_L, 3'd0, 32'h103, 32'd0, 32'h80000000, 1, 1'b0);
    total++;
    if (load_data !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_const got=%h want=ffffff80", load_data); end
    run_txn(OPC_L, 3'd4, 32'h103, 32'd0, 32'h80000000, 2, 1'b0);
    total++;
    if (load_data !== 32'h00000080) begin bad++; $display("FAIL lbu_const got=%h want=00000080", load_data); end
    run_txn(OPC_S, 3'd1, 32'h202, 32'h1234ABCD, 32'h55555555, 1, 1'b0);
    total++;
    if (load_data !== 32'h00000080) begin bad++; $display("FAIL sh_keeps_load got=%h want=00000080", load_data); end
  endtask

  task automatic test_timeout_late_ack();
    run_txn(OPC_L, 3'd2, 32'h40, 32'd0, 32'h11111111, TO + 1, 1'b0);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_ack = 1'b0;
    total++;
    if ({busy, done, err, mem_req} !== 4'b0000 || load_data !== exp_load) begin
      bad++; $display("FAIL late_ack ctl=%b load=%h want 0000 %h", {busy, done, err, mem_req}, load_data, exp_load);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    opcode = OPC_L; funct3 = 3'd2; addr = 32'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL mid_req req=%b want 1", mem_req); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || load_data !== 32'd0) begin
      bad++; $display("FAIL async_reset req=%b busy=%b load=%h want 0 0 0", mem_req, busy, load_data);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_load = 32'd0;
    run_txn(OPC_L, 3'd5, 32'h6, 32'd0, 32'hF00F0000, 1, 1'b0);
    total++;
    if (load_data !== 32'h0000F00F) begin bad++; $display("FAIL lhu_const got=%h want=0000f00f", load_data); end
  endtask

  task automatic test_misalign_illegal();
    run_txn(OPC_L, 3'd2, 32'h101, 32'd0, 32'h01020304, 1, 1'b0);
`ifndef LSU_MISALIGN_TRAP_EN
    total++;
    if (load_data !== 32'h01020304) begin bad++; $display("FAIL lw_misalign got=%h want=01020304", load_data); end
`endif
    run_txn(OPC_L, 3'd3, 32'h10, 32'd0, 32'd0, 1, 1'b0);
    run_txn(OPC_S, 3'd4, 32'h10, 32'h5, 32'd0, 1, 1'b0);
    run_txn(7'h33, 3'd2, 32'h10, 32'h5, 32'd0, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [6:0]  op;
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       op = 7'h13;
        1, 3, 5, 7, 9: op = OPC_L;
        default: op = OPC_S;
      endcase
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      run_txn(op, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
              $urandom_range(1, TO + 1), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_directed();
    test_timeout_late_ack();
    test_reset_mid();
    test_misalign_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
